// File: rtl/pipe_stage_skid.sv
// rtl/pipe_stage_skid.sv - valid/ready pipeline register with 2-entry skid buffer
// PIPE_STATS_EN adds saturating stall_cnt/flush_cnt statistics ports.
module pipe_stage_skid #(
    parameter int CTRL_W = 8,
    parameter int DATA_W = 77,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data
`ifdef PIPE_STATS_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
`endif
);

    logic              m_valid, s_valid;
    logic [CTRL_W-1:0] m_ctrl, s_ctrl;
    logic [DATA_W-1:0] m_data, s_data;
    logic              accept, deliver;

    // in_ready comes straight from the skid flop, so out_ready never reaches it combinationally
    assign in_ready  = ~s_valid;
    assign accept    = in_valid & ~s_valid;
    assign deliver   = m_valid & out_ready;
    assign out_valid = m_valid;
    assign out_ctrl  = m_ctrl;
    assign out_data  = m_data;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            m_valid <= 1'b0;
            m_ctrl  <= '0;
            m_data  <= '0;
            s_valid <= 1'b0;
            s_ctrl  <= '0;
            s_data  <= '0;
        end else if (!m_valid || deliver) begin
            // M is free this cycle: refill from skid first to keep FIFO order
            if (s_valid) begin
                m_valid <= 1'b1;
                m_ctrl  <= s_ctrl;
                m_data  <= s_data;
                s_valid <= 1'b0;
                s_ctrl  <= '0;
                s_data  <= '0;
            end else if (accept) begin
                m_valid <= 1'b1;
                m_ctrl  <= in_ctrl;
                m_data  <= in_data;
            end else begin
                m_valid <= 1'b0;
                m_ctrl  <= '0;
                m_data  <= '0;
            end
        end else if (accept) begin
            s_valid <= 1'b1;
            s_ctrl  <= in_ctrl;
            s_data  <= in_data;
        end
    end

`ifdef PIPE_STATS_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (m_valid && !out_ready && stall_cnt != CNT_MAX) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if (flush && (m_valid || s_valid) && flush_cnt != CNT_MAX) begin
                flush_cnt <= flush_cnt + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb/tb_pipe_stage_skid.sv - scoreboard bench for pipe_stage_skid
// Covers PIPE_STATS_EN counters when the macro is defined.
module tb_pipe_stage_skid;

    localparam int CW = 8;
    localparam int DW = 77;
    localparam int NW = 4;

    typedef struct {
        logic [CW-1:0] c;
        logic [DW-1:0] d;
    } beat_t;

    logic          clk;
    logic          rst;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [CW-1:0] in_ctrl;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] out_ctrl;
    logic [DW-1:0] out_data;
`ifdef PIPE_STATS_EN
    logic [NW-1:0] stall_cnt;
    logic [NW-1:0] flush_cnt;
`endif

    pipe_stage_skid #(.CTRL_W(CW), .DATA_W(DW), .CNT_W(NW)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ctrl   (in_ctrl),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ctrl  (out_ctrl),
        .out_data  (out_data)
`ifdef PIPE_STATS_EN
        ,
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
`endif
    );

    // Beats held by the stage, oldest first: a 2-deep FIFO that flush/rst empties
    beat_t exp_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;
    bit    mon_en   = 0;
    int    sz;
    int    m_stall  = 0;
    int    m_flush  = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h required=%h t=%0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] rand_data();
        logic [95:0] r;
        r = {$urandom, $urandom, $urandom};
        return r[DW-1:0];
    endfunction

    // Drive one cycle; model update happens right after the edge that samples it
    task automatic step(input logic r, input logic f, input logic iv,
                        input logic [CW-1:0] c, input logic [DW-1:0] d, input logic ordy);
        bit acc;
        beat_t b;
        rst = r; flush = f; in_valid = iv; in_ctrl = c; in_data = d; out_ready = ordy;
        acc = iv && (exp_q.size() < 2);
        @(posedge clk);
        if (r || f) begin
            exp_q.delete();
        end else if (acc) begin
            b.c = c;
            b.d = d;
            exp_q.push_back(b);
        end
        #1;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            sz = exp_q.size();
            chk("in_ready", 128'(in_ready), 128'(sz < 2));
            chk("out_valid", 128'(out_valid), 128'(sz > 0));
            if (sz > 0) begin
                chk("out_ctrl", 128'(out_ctrl), 128'(exp_q[0].c));
                chk("out_data", 128'(out_data), 128'(exp_q[0].d));
                if (out_ready && !rst) void'(exp_q.pop_front());
            end else begin
                chk("bubble_ctrl", 128'(out_ctrl), 128'(0));
                chk("bubble_data", 128'(out_data), 128'(0));
            end
`ifdef PIPE_STATS_EN
            chk("stall_cnt", 128'(stall_cnt), 128'(m_stall));
            chk("flush_cnt", 128'(flush_cnt), 128'(m_flush));
            if (rst) begin
                m_stall = 0;
                m_flush = 0;
            end else begin
                if (sz > 0 && !out_ready && m_stall < (1 << NW) - 1) m_stall++;
                if (flush && sz > 0 && m_flush < (1 << NW) - 1) m_flush++;
            end
`endif
        end
    end

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_ctrl = '0; in_data = '0; out_ready = 1'b0;
        step(1, 0, 1, 8'hAA, 77'h5A5, 1);
        step(1, 0, 1, 8'hAB, 77'h5A6, 1);
        mon_en = 1;
        chk("post_reset_empty", 128'(exp_q.size()), 128'(0));
        step(0, 0, 0, 8'h00, 77'h0, 1);

        for (int i = 1; i <= 5; i++) step(0, 0, 1, CW'(i), DW'(i), 1);
        step(0, 0, 0, 8'h00, 77'h0, 1);
        step(0, 0, 0, 8'h00, 77'h0, 1);

        step(0, 0, 1, 8'h11, 77'h111, 0);
        step(0, 0, 1, 8'h22, 77'h222, 0);
        step(0, 0, 1, 8'h33, 77'h333, 0);
        step(0, 0, 1, 8'h33, 77'h333, 0);
        step(0, 0, 0, 8'h00, 77'h0, 1);
        step(0, 0, 0, 8'h00, 77'h0, 1);
        step(0, 0, 0, 8'h00, 77'h0, 1);

        step(0, 0, 1, 8'h11, 77'h111, 0);
        step(0, 0, 1, 8'h22, 77'h222, 0);
        step(0, 1, 1, 8'h33, 77'h333, 0);
        step(0, 0, 0, 8'h00, 77'h0, 1);
        step(0, 0, 0, 8'h00, 77'h0, 1);

        step(0, 0, 1, 8'h44, 77'h444, 0);
        step(0, 1, 0, 8'h00, 77'h0, 1);
        step(0, 0, 0, 8'h00, 77'h0, 1);

        step(0, 0, 1, 8'h55, 77'h555, 0);
        step(0, 0, 1, 8'h66, 77'h666, 0);
        step(1, 0, 1, 8'h77, 77'h777, 0);
        step(0, 0, 0, 8'h00, 77'h0, 1);

`ifdef PIPE_STATS_EN
        step(1, 0, 0, 8'h00, 77'h0, 0);
        step(0, 0, 1, 8'h81, 77'h81, 0);
        for (int i = 0; i < 20; i++) step(0, 0, 0, 8'h00, 77'h0, 0);
        chk("stall_sat", 128'(stall_cnt), 128'(15));
        step(0, 1, 0, 8'h00, 77'h0, 0);
        step(0, 0, 1, 8'h82, 77'h82, 0);
        step(0, 1, 0, 8'h00, 77'h0, 0);
        step(0, 1, 0, 8'h00, 77'h0, 0);
        step(0, 0, 0, 8'h00, 77'h0, 1);
        chk("flush_total", 128'(flush_cnt), 128'(2));
`endif

        for (int i = 0; i < 500; i++) begin
            step(($urandom_range(0, 127) == 0), ($urandom_range(0, 19) == 0),
                 ($urandom_range(0, 3) != 0), CW'($urandom), rand_data(),
                 ($urandom_range(0, 9) < 7));
        end

        for (int i = 0; i < 4; i++) step(0, 0, 0, 8'h00, 77'h0, 1);
        chk("drained", 128'(exp_q.size()), 128'(0));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Parametrised inter-stage pipeline register, successor to the fixed EX/MEM latch. Drop-in between any two CPU stages (ID/EX, EX/MEM, MEM/WB).
- Carries a control bundle and a data bundle under a valid/ready handshake.
- A 2-entry skid buffer registers the ready path.
- Supports flush (bubble insertion) and downstream stall without losing or duplicating beats.

Parameters:
- CTRL_W, 8, width of control bundle (regwrite, memtoreg, branch, memwrite, bgtz, ...).
- DATA_W, 77, width of data bundle (e.g. addresult 8 + aluresult 32 + r2_dout 32 + rd 5).
- CNT_W, 16, width of statistics counters (used only with PIPE_STATS_EN).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- flush  input  1  kill all held beats this cycle.
- in_valid  input  1  upstream beat present.
- in_ready  output  1  block can accept a beat.
- in_ctrl  input  CTRL_W  upstream control bundle.
- in_data  input  DATA_W  upstream data bundle.
- out_valid  output  1  beat present at output.
- out_ready  input  1  downstream accepts beat.
- out_ctrl  output  CTRL_W  held control bundle; zero when out_valid=0.
- out_data  output  DATA_W  held data bundle; zero when out_valid=0.
- stall_cnt  output  CNT_W  only with PIPE_STATS_EN.
- flush_cnt  output  CNT_W  only with PIPE_STATS_EN.

Behaviour:
- Interface: one clock; reset is synchronous and active-high (clk, rst).
- Storage: main entry M (drives outputs) and skid entry S, each holding {valid, ctrl, data}.
- Reset: M.valid=S.valid=0, all ctrl/data=0, in_ready=1, out_valid=0, out_ctrl=0, out_data=0, counters=0.
- in_ready is registered: in_ready = ~S.valid. No combinational path from out_ready to in_ready.
- Accept: in_valid & in_ready at a posedge. Deliver: out_valid & out_ready at a posedge.
- Latency 1 cycle from accept to out_valid when M is empty or drained the same cycle. Throughput 1 beat/cycle sustained.
- Transitions:
  - M empty, accept → M loads input.
  - M full, deliver, accept, S empty → M loads input.
  - M full, no deliver, accept → S loads input; in_ready drops next cycle.
  - M full, deliver, S full → M loads S; S clears; in_ready=1 next cycle. No accept is possible in this case.
  - M full, deliver, no accept, S empty → M.valid=0, M ctrl/data zeroed.
- Order is strictly FIFO. No beat is dropped or duplicated except by flush.
- Flush (priority over everything except rst): next cycle M and S are invalid with ctrl and data zeroed.
  - A same-cycle accept is discarded.
  - A same-cycle deliver still completes downstream (beat already presented).
  - in_ready=1 the cycle after the flush.
- Flush while empty: no state change.
- Reset mid-transfer: all held beats are lost; state equals the post-reset state.
- out_valid=0 always implies out_ctrl=0 and out_data=0, so downstream sees a clean bubble (regwrite/memwrite=0).
- Held outputs stay stable while out_valid & ~out_ready.

Optional Feature:
- Macro PIPE_STATS_EN.
- Defined:
  - stall_cnt increments each cycle with out_valid & ~out_ready.
  - flush_cnt increments each flush cycle in which M.valid|S.valid=1.
  - Both counters saturate at 2^CNT_W-1 and clear on rst.
- Undefined: the counter ports and logic do not exist; the port list ends at out_data.

Test Plan:
- Reset: rst=1 for 2 cycles with in_valid=1 → out_valid=0, out_ctrl=0, out_data=0, in_ready=1; after release no beat appears until a new accept.
- Streaming: out_ready=1, beats ctrl=0x01..0x05, data=1..5 on consecutive cycles → each appears 1 cycle later, order 1..5, in_ready held 1.
- Stall/skid: send A=0x11 then B=0x22 with out_ready=0 → out shows A stable, in_ready=0 after B. Raise out_ready → A, then B on the next cycle, in_ready=1 one cycle later. C offered while in_ready=0 is not taken.
- Flush: M=A, S=B, flush=1 with in_valid=1 (C=0x33) → next cycle out_valid=0, ctrl/data=0, in_ready=1; C never appears.
- Flush+deliver: M=A, out_ready=1, flush=1 → A counted delivered, no further beats.
- Stats (PIPE_STATS_EN, CNT_W=4): hold out_valid with out_ready=0 for 20 cycles → stall_cnt=15 (saturated). Two flushes with data held plus one flush while empty → flush_cnt=2.
